// File: rtl/mdio_responder.sv
// Clause 22 MDIO target endpoint.
// Oversamples MDC/MDIO in the clk domain, decodes read/write frames addressed
// to phy_addr and turns them into single-cycle register strobes. Read data is
// driven back onto MDIO on falling MDC edges.
// Optional build macro: MDIO_RESPONDER_BROADCAST_EN -- also accept PHYAD=0
// for write frames (broadcast write).
module mdio_responder #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  phy_addr,
  input  logic        mdc,
  input  logic        mdio_rx,
  output logic        mdio_tx,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr,
  output logic [15:0] reg_wr_data,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [3:0] {
    IDLE,
    ST1,
    OP,
    PHYAD,
    REGAD,
    RD,
    TA_WR,
    WDATA,
    SKIP
  } state_t;

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  // Synchroniser / edge-detect pipeline
  logic mdc_p0, mdc_p1, mdc_p2;
  logic mdio_p0, mdio_p1;
  logic rise, fall, bit_in;

  // FSM and datapath state
  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [5:0]  pre_cnt, pre_nx;
  logic [15:0] shift, shift_nx;
  logic        op_rd, op_rd_nx;
  logic        rd_vld_p1;
  logic        tx_nx, oe_nx, rd_nx, wr_nx, err_nx;
  logic [4:0]  addr_nx;
  logic [15:0] wdata_nx;
  logic [4:0]  phyad_in;
  logic        phy_match;

  // Two-flop synchronisers for MDC and MDIO plus MDC edge-detect register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_p0  <= 1'b0;
      mdc_p1  <= 1'b0;
      mdc_p2  <= 1'b0;
      mdio_p0 <= 1'b1;
      mdio_p1 <= 1'b1;
    end else begin
      mdc_p0  <= mdc;
      mdc_p1  <= mdc_p0;
      mdc_p2  <= mdc_p1;
      mdio_p0 <= mdio_rx;
      mdio_p1 <= mdio_p0;
    end
  end

  assign rise   = mdc_p1 & ~mdc_p2;
  assign fall   = ~mdc_p1 & mdc_p2;
  assign bit_in = mdio_p1;
  assign busy   = (state != IDLE);

  // Address of the frame, complete on the last PHYAD rise
  assign phyad_in = {shift[3:0], bit_in};

`ifdef MDIO_RESPONDER_BROADCAST_EN
  // Broadcast address 0 only for writes so responders never contend on reads
  assign phy_match = (phyad_in == phy_addr) || ((phyad_in == 5'd0) && !op_rd);
`else
  assign phy_match = (phyad_in == phy_addr);
`endif

  // Next-state, counters, shift register and output next values
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pre_nx   = pre_cnt;
    shift_nx = shift;
    op_rd_nx = op_rd;
    tx_nx    = mdio_tx;
    oe_nx    = mdio_oe;
    rd_nx    = 1'b0;
    wr_nx    = 1'b0;
    err_nx   = 1'b0;
    addr_nx  = reg_addr;
    wdata_nx = reg_wr_data;

    // Register file answers one clk after the read strobe
    if (rd_vld_p1) begin
      shift_nx = reg_rd_data;
    end

    unique case (state)
      IDLE: begin
        if (rise) begin
          if (bit_in) begin
            if (pre_cnt < PRE_MAX) begin
              pre_nx = pre_cnt + 6'd1;
            end
          end else begin
            // A zero either starts the frame or discards a short preamble
            pre_nx = '0;
            if (pre_cnt >= PRE_MAX) begin
              state_nx = ST1;
            end
          end
        end
      end

      ST1: begin
        if (rise) begin
          if (bit_in) begin
            state_nx = OP;
            cnt_nx   = '0;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end

      OP: begin
        if (rise) begin
          shift_nx = {shift[14:0], bit_in};
          if (cnt == 5'd0) begin
            cnt_nx = 5'd1;
          end else begin
            cnt_nx = '0;
            if ({shift[0], bit_in} == 2'b10) begin
              op_rd_nx = 1'b1;
              state_nx = PHYAD;
            end else if ({shift[0], bit_in} == 2'b01) begin
              op_rd_nx = 1'b0;
              state_nx = PHYAD;
            end else begin
              err_nx   = 1'b1;
              state_nx = IDLE;
            end
          end
        end
      end

      PHYAD: begin
        if (rise) begin
          shift_nx = {shift[14:0], bit_in};
          if (cnt == 5'd4) begin
            cnt_nx = '0;
            if (phy_match) begin
              state_nx = REGAD;
            end else begin
              // Not ours: let REGAD, TA and data (5+2+16 rises) pass silently
              state_nx = SKIP;
              cnt_nx   = 5'd23;
            end
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
      end

      REGAD: begin
        if (rise) begin
          shift_nx = {shift[14:0], bit_in};
          if (cnt == 5'd4) begin
            cnt_nx  = '0;
            addr_nx = {shift[3:0], bit_in};
            if (op_rd) begin
              rd_nx    = 1'b1;
              state_nx = RD;
            end else begin
              state_nx = TA_WR;
            end
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
      end

      RD: begin
        // cnt counts rises after REGAD: 1..2 are TA, 3..18 are data bits
        if (rise) begin
          cnt_nx = cnt + 5'd1;
        end else if (fall) begin
          if (cnt == 5'd1) begin
            oe_nx = 1'b1;
            tx_nx = 1'b0;
          end else if ((cnt >= 5'd2) && (cnt <= 5'd17)) begin
            tx_nx    = shift[15];
            shift_nx = {shift[14:0], 1'b0};
          end else if (cnt == 5'd18) begin
            oe_nx    = 1'b0;
            tx_nx    = 1'b0;
            cnt_nx   = '0;
            pre_nx   = '0;
            state_nx = IDLE;
          end
        end
      end

      TA_WR: begin
        if (rise) begin
          shift_nx = {shift[14:0], bit_in};
          if (cnt == 5'd0) begin
            cnt_nx = 5'd1;
          end else begin
            cnt_nx = '0;
            if ({shift[0], bit_in} == 2'b10) begin
              state_nx = WDATA;
            end else begin
              err_nx   = 1'b1;
              state_nx = SKIP;
              cnt_nx   = 5'd16;
            end
          end
        end
      end

      WDATA: begin
        if (rise) begin
          shift_nx = {shift[14:0], bit_in};
          if (cnt == 5'd15) begin
            wdata_nx = {shift[14:0], bit_in};
            wr_nx    = 1'b1;
            cnt_nx   = '0;
            pre_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
      end

      SKIP: begin
        if (rise) begin
          if (cnt <= 5'd1) begin
            cnt_nx   = '0;
            pre_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt - 5'd1;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pre_cnt     <= '0;
      op_rd       <= 1'b0;
      rd_vld_p1   <= 1'b0;
      mdio_tx     <= 1'b0;
      mdio_oe     <= 1'b0;
      reg_addr    <= '0;
      reg_rd      <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pre_cnt     <= pre_nx;
      op_rd       <= op_rd_nx;
      rd_vld_p1   <= reg_rd;
      mdio_tx     <= tx_nx;
      mdio_oe     <= oe_nx;
      reg_addr    <= addr_nx;
      reg_rd      <= rd_nx;
      reg_wr      <= wr_nx;
      reg_wr_data <= wdata_nx;
      frame_err   <= err_nx;
    end
  end

  // Frame shift register (pure data, no reset)
  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a bus-master model issues directed MDIO frames,
// expected strobes/read words are queued at issue time and popped by
// independent monitors when the DUT produces them.
module tb_mdio_responder;

  logic        clk;
  logic        rst;
  logic [4:0]  phy_addr;
  logic        mdc;
  logic        mdio_rx;
  logic        mdio_tx;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_rd;
  logic [15:0] reg_rd_data;
  logic        reg_wr;
  logic [15:0] reg_wr_data;
  logic        busy;
  logic        frame_err;

  // Master drive state; released bus floats high (pull-up)
  logic        m_en;
  logic        m_bit;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  exp_rd_addr[$];
  logic [20:0] exp_wr[$];
  logic [15:0] exp_rdata[$];
  int          exp_err = 0;

  logic [15:0] mem [32];
  logic [16:0] rd_word;
  int          rd_bits;

  mdio_responder #(.PREAMBLE_LEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .phy_addr    (phy_addr),
    .mdc         (mdc),
    .mdio_rx     (mdio_rx),
    .mdio_tx     (mdio_tx),
    .mdio_oe     (mdio_oe),
    .reg_addr    (reg_addr),
    .reg_rd      (reg_rd),
    .reg_rd_data (reg_rd_data),
    .reg_wr      (reg_wr),
    .reg_wr_data (reg_wr_data),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  assign mdio_rx = mdio_oe ? mdio_tx : (m_en ? m_bit : 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: data valid one clk after reg_rd
  always @(posedge clk) begin
    if (reg_rd) reg_rd_data <= mem[reg_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Strobe / error monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_rd && reg_wr) check("strobe_overlap", 32'(reg_wr), 32'd0);
      if (reg_rd) begin
        if (exp_rd_addr.size() == 0) check("rd_unexpected", 32'(reg_rd), 32'd0);
        else check("rd_addr", 32'(reg_addr), 32'(exp_rd_addr.pop_front()));
      end
      if (reg_wr) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 32'(reg_wr), 32'd0);
        else check("wr_addr_data", 32'({reg_addr, reg_wr_data}), 32'(exp_wr.pop_front()));
      end
      if (frame_err) begin
        if (exp_err == 0) check("err_unexpected", 32'(frame_err), 32'd0);
        else exp_err--;
      end
    end
  end

  // Bus monitor: turnaround bit 2 and data sampled on MDC rise while driven
  always @(posedge mdio_oe) begin
    check("oe_only_on_read", 32'(exp_rdata.size() > 0), 32'd1);
    rd_word = '0;
    rd_bits = 0;
  end

  always @(posedge mdc) begin
    if (mdio_oe) begin
      rd_word = {rd_word[15:0], mdio_tx};
      rd_bits++;
    end
  end

  always @(negedge mdio_oe) begin
    if (exp_rdata.size() > 0) begin
      logic [15:0] e;
      e = exp_rdata.pop_front();
      if (!rst) begin
        check("rd_bits", 32'(rd_bits), 32'd17);
        check("rd_word", 32'(rd_word), 32'({1'b0, e}));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic mdc_cycle(input logic b);
    m_bit = b;
    repeat (8) @(negedge clk);
    mdc = 1'b1;
    repeat (8) @(negedge clk);
    mdc = 1'b0;
  endtask

  // Full or truncated frame; tail_bits counts TA+data cycles issued (18 = full)
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                       input bit rd, input int tail_bits, input bit exp_busy, input string tag);
    m_en = 1'b1;
    for (int i = 0; i < pre; i++) mdc_cycle(1'b1);
    mdc_cycle(1'b0);
    mdc_cycle(1'b1);
    mdc_cycle(op[1]);
    mdc_cycle(op[0]);
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    for (int i = 4; i >= 0; i--) mdc_cycle(phy[i]);
    for (int i = 4; i >= 0; i--) mdc_cycle(ra[i]);
    if (rd) m_en = 1'b0;
    for (int t = 0; t < tail_bits; t++) begin
      if (t < 2) mdc_cycle(ta[1 - t]);
      else mdc_cycle(wd[17 - t]);
    end
    m_en = 1'b1;
    m_bit = 1'b1;
  endtask

  task automatic settle(input string tag);
    repeat (12) @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_oe_off"}, 32'(mdio_oe), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mdc = 1'b0;
    m_en = 1'b1;
    m_bit = 1'b1;
    phy_addr = 5'd5;
    reg_rd_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[3] = 16'hA55A;
    mem[7] = 16'h8001;
    repeat (4) @(negedge clk);

    check("rst_oe", 32'(mdio_oe), 32'd0);
    check("rst_tx", 32'(mdio_tx), 32'd0);
    check("rst_strobes", 32'({reg_rd, reg_wr, frame_err}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr_wdata", 32'({reg_addr, reg_wr_data}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Read PHY 5 reg 3
    exp_rd_addr.push_back(5'd3);
    exp_rdata.push_back(16'hA55A);
    frame(32, 2'b10, 5'd5, 5'd3, 2'b00, 16'h0000, 1'b1, 18, 1'b1, "rd1");
    settle("rd1");

    // Write PHY 5 reg 31
    exp_wr.push_back({5'd31, 16'h1234});
    frame(32, 2'b01, 5'd5, 5'd31, 2'b10, 16'h1234, 1'b0, 18, 1'b1, "wr1");
    settle("wr1");

    // Read to another PHY, then a read to us
    frame(32, 2'b10, 5'd6, 5'd3, 2'b00, 16'h0000, 1'b1, 18, 1'b1, "skip");
    settle("skip");
    exp_rd_addr.push_back(5'd7);
    exp_rdata.push_back(16'h8001);
    frame(32, 2'b10, 5'd5, 5'd7, 2'b00, 16'h0000, 1'b1, 18, 1'b1, "rd2");
    settle("rd2");

    // Short preamble: frame ignored, no error
    frame(20, 2'b10, 5'd5, 5'd3, 2'b00, 16'h0000, 1'b1, 18, 1'b0, "shortpre");
    settle("shortpre");

    // Illegal opcode
    exp_err++;
    frame(32, 2'b11, 5'd5, 5'd3, 2'b10, 16'h0000, 1'b0, 18, 1'b0, "op11");
    settle("op11");
    check("op11_err_seen", 32'(exp_err), 32'd0);

    // Write with bad turnaround
    exp_err++;
    frame(32, 2'b01, 5'd5, 5'd9, 2'b11, 16'h5555, 1'b0, 18, 1'b1, "ta11");
    settle("ta11");
    check("ta11_err_seen", 32'(exp_err), 32'd0);

    // Broadcast write
`ifdef MDIO_RESPONDER_BROADCAST_EN
    exp_wr.push_back({5'd2, 16'hBEEF});
`endif
    frame(32, 2'b01, 5'd0, 5'd2, 2'b10, 16'hBEEF, 1'b0, 18, 1'b1, "bcast");
    settle("bcast");

    // Reset during read data bit 8
    exp_rd_addr.push_back(5'd3);
    exp_rdata.push_back(16'hA55A);
    frame(32, 2'b10, 5'd5, 5'd3, 2'b00, 16'h0000, 1'b1, 10, 1'b1, "abort");
    repeat (5) @(negedge clk);
    check("abort_oe_before", 32'(mdio_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_oe", 32'(mdio_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    exp_rd_addr.push_back(5'd3);
    exp_rdata.push_back(16'hA55A);
    frame(32, 2'b10, 5'd5, 5'd3, 2'b00, 16'h0000, 1'b1, 18, 1'b1, "rd3");
    settle("rd3");

    check("pending_rd", 32'(exp_rd_addr.size()), 32'd0);
    check("pending_wr", 32'(exp_wr.size()), 32'd0);
    check("pending_rdata", 32'(exp_rdata.size()), 32'd0);
    check("pending_err", 32'(exp_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
